// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: FIFO read-side controller with registered one-deep prefetch output stage
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk_read,
    input  logic                  RST,
    input  logic [ADDR_WIDTH:0]   i_wr_ptr,
    input  logic                  i_flush,
    output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
    output logic                  o_ram_rd_en,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH:0]   o_rd_ptr,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_level
);
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d, rd_ptr_inc;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  fetch;

    assign o_empty       = i_wr_ptr == rd_ptr_q;
    assign o_level       = i_wr_ptr - rd_ptr_q;
    assign fetch         = !o_empty && (!valid_q || i_ready) && !i_flush;
    assign o_ram_rd_en   = fetch;
    assign o_ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign o_rd_ptr      = rd_ptr_q;
    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign rd_ptr_inc    = (rd_ptr_q[ADDR_WIDTH-1:0] == ADDR_WIDTH'(DEPTH - 1))
                         ? {~rd_ptr_q[ADDR_WIDTH], {ADDR_WIDTH{1'b0}}}
                         : rd_ptr_q + (ADDR_WIDTH+1)'(1);

    // next state: flush beats fetch, fetch beats a plain pop, otherwise hold
    always_comb begin
        rd_ptr_d = i_flush ? i_wr_ptr : fetch ? rd_ptr_inc : rd_ptr_q;
        data_d   = fetch ? i_ram_rd_data : data_q;
        valid_d  = i_flush ? 1'b0 : fetch ? 1'b1 : (valid_q && !i_ready);
    end

    // pointer and output-stage registers
    always_ff @(posedge clk_read or negedge RST) begin
        if (!RST) begin
            rd_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: scoreboard bench for fifo_rd_ctrl with a behavioural storage array
module tb_fifo_rd_ctrl;
    logic       clk_read = 1'b0;
    logic       RST;
    logic [5:0] i_wr_ptr;
    logic       i_flush;
    logic [4:0] o_ram_rd_addr;
    logic       o_ram_rd_en;
    logic [7:0] i_ram_rd_data;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic [5:0] o_rd_ptr;
    logic       o_empty;
    logic [5:0] o_level;

    logic [7:0] mem [32];
    logic [7:0] exp_q [$];
    int n_checks = 0;
    int n_fail = 0;

    fifo_rd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32)) dut (
        .clk_read(clk_read), .RST(RST), .i_wr_ptr(i_wr_ptr), .i_flush(i_flush),
        .o_ram_rd_addr(o_ram_rd_addr), .o_ram_rd_en(o_ram_rd_en), .i_ram_rd_data(i_ram_rd_data),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_rd_ptr(o_rd_ptr), .o_empty(o_empty), .o_level(o_level)
    );

    always #5 clk_read = ~clk_read;

    assign i_ram_rd_data = mem[o_ram_rd_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_read);
        #1;
    endtask

    task automatic wr_word(input logic [7:0] d);
        mem[i_wr_ptr[4:0]] = d;
        i_wr_ptr = i_wr_ptr + 6'd1;
        exp_q.push_back(d);
    endtask

    // monitor: every accepted output word must match the oldest expected word
    always @(negedge clk_read) begin
        if (RST && o_valid && i_ready && !i_flush) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none", o_data);
            end else begin
                chk("data_order", o_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int written, c, max_level, seen_wrap;
        logic [4:0] wrap_addr;
        RST = 1'b0; i_wr_ptr = '0; i_ready = 1'b0; i_flush = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        repeat (3) tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_rd_ptr", o_rd_ptr, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_level", o_level, 0);
        chk("rst_rd_en", o_ram_rd_en, 0);
        RST = 1'b1;
        tick();

        wr_word(8'hA5);
        #1;
        chk("single_rd_en", o_ram_rd_en, 1);
        chk("single_level", o_level, 1);
        tick();
        chk("single_data", o_data, 8'hA5);
        chk("single_valid", o_valid, 1);
        chk("single_rd_ptr", o_rd_ptr, 1);
        chk("single_empty", o_empty, 1);
        chk("single_rd_en_off", o_ram_rd_en, 0);
        repeat (5) begin
            tick();
            chk("bp_data", o_data, 8'hA5);
            chk("bp_valid", o_valid, 1);
            chk("bp_rd_ptr", o_rd_ptr, 1);
        end
        i_ready = 1'b1;
        tick();
        chk("single_drained", o_valid, 0);
        i_ready = 1'b0;

        for (int i = 0; i < 10; i++) wr_word(8'(i));
        tick();
        chk("stream_pre_level", o_level, 9);
        chk("stream_pre_valid", o_valid, 1);
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stream_valid", o_valid, 1);
            tick();
        end
        chk("stream_end_valid", o_valid, 0);
        chk("stream_end_level", o_level, 0);
        chk("stream_end_empty", o_empty, 1);
        chk("stream_end_rd_ptr", o_rd_ptr, 11);
        i_ready = 1'b0;

        wr_word(8'h3C);
        tick();
        chk("pre_rst_valid", o_valid, 1);
        #2;
        RST = 1'b0;
        i_wr_ptr = '0;
        exp_q.delete();
        #1;
        chk("async_rst_valid", o_valid, 0);
        chk("async_rst_rd_ptr", o_rd_ptr, 0);
        chk("async_rst_data", o_data, 0);
        tick();
        RST = 1'b1;

        written = 0; c = 0; max_level = 0; seen_wrap = 0; wrap_addr = '1;
        while (!(o_rd_ptr == 6'd40 && !o_valid) && c < 600) begin
            if (int'(o_level) > max_level) max_level = int'(o_level);
            if (o_rd_ptr == 6'd32) begin
                seen_wrap = 1;
                wrap_addr = o_ram_rd_addr;
            end
            i_ready = (c >= 36) && (c % 3 != 0);
            if (written < 40 && o_level < 6'd32) begin
                wr_word(8'(written) ^ 8'h5A);
                written++;
            end
            tick();
            c++;
        end
        chk("wrap_rd_ptr", o_rd_ptr, 40);
        chk("wrap_empty", o_empty, 1);
        chk("wrap_seen_msb", seen_wrap, 1);
        chk("wrap_addr_zero", wrap_addr, 0);
        chk("wrap_max_level", max_level, 32);
        chk("wrap_written", written, 40);
        chk("wrap_queue_empty", exp_q.size(), 0);
        i_ready = 1'b0;

        for (int i = 0; i < 7; i++) wr_word(8'(i) + 8'hC0);
        tick();
        chk("flush_pre_level", o_level, 6);
        chk("flush_pre_valid", o_valid, 1);
        i_flush = 1'b1;
        exp_q.delete();
        #1;
        chk("flush_rd_en", o_ram_rd_en, 0);
        tick();
        i_flush = 1'b0;
        chk("flush_valid", o_valid, 0);
        chk("flush_rd_ptr", o_rd_ptr, 47);
        chk("flush_empty", o_empty, 1);
        chk("flush_level", o_level, 0);
        chk("flush_data_hold", o_data, 8'hC0);

        RST = 1'b0;
        #1;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'(i) + 8'd100;
            exp_q.push_back(8'(i) + 8'd100);
        end
        i_wr_ptr = 6'd32;
        #1;
        chk("full_rst_level", o_level, 32);
        chk("full_rst_empty", o_empty, 0);
        chk("full_rst_valid", o_valid, 0);
        tick();
        RST = 1'b1;
        tick();
        chk("full_level", o_level, 31);
        chk("full_valid", o_valid, 1);
        chk("full_data", o_data, 100);
        chk("full_rd_ptr", o_rd_ptr, 1);
        i_ready = 1'b1;
        c = 0;
        while (o_valid && c < 100) begin
            tick();
            c++;
        end
        chk("full_drain_rd_ptr", o_rd_ptr, 32);
        chk("full_drain_empty", o_empty, 1);
        chk("full_drain_valid", o_valid, 0);
        chk("full_queue_empty", exp_q.size(), 0);
        i_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
